alu_mult_sequencer: RTL and testbench

ALU_MULT_SEQUENCER -- requirements
Module: alu_mult_sequencer

---
 rtl/alu_mult_sequencer.sv | 63 ++++++
 tb/tb_alu_mult_sequencer.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/alu_mult_sequencer.sv
// alu_mult_sequencer: 64x64 shift-and-add multiplier (low 64 bits) that borrows an
// external combinational ALU for every add and shift on its working registers.
module alu_mult_sequencer #(
  parameter logic [4:0] FS_ADD = 5'b01000,
  parameter logic [4:0] FS_SHL = 5'b10000,
  parameter logic [4:0] FS_SHR = 5'b10100
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [63:0] op_a,
  input  logic [63:0] op_b,
  input  logic [63:0] alu_F,
  output logic [4:0]  alu_FS,
  output logic [63:0] alu_A,
  output logic [63:0] alu_B,
  output logic [63:0] product,
  output logic        busy,
  output logic        done
);
  typedef enum logic [2:0] {IDLE, ADD, SHL, SHR, DONE} state_t;
  state_t r_state, w_next, w_dispatch;
  logic [63:0] r_acc, r_mcand, r_mplr, w_mplr_next;
  // The next multiplier value (fresh op_b or the ALU's shift result) picks the next step
  always_comb begin
    w_mplr_next = (r_state == IDLE) ? op_b : alu_F;
    w_dispatch = (w_mplr_next == '0) ? DONE : (w_mplr_next[0] ? ADD : SHL);
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = start ? w_dispatch : IDLE;
      ADD:     w_next = SHL;
      SHL:     w_next = SHR;
      SHR:     w_next = w_dispatch;
      default: w_next = IDLE;
    endcase
  end
  always_comb begin
    alu_FS = (r_state == ADD) ? FS_ADD : (r_state == SHL) ? FS_SHL : (r_state == SHR) ? FS_SHR : 5'b00000;
    alu_A  = (r_state == ADD) ? r_acc : (r_state == SHL) ? r_mcand : (r_state == SHR) ? r_mplr : 64'd0;
    alu_B  = (r_state == ADD) ? r_mcand : (r_state == SHL || r_state == SHR) ? 64'd1 : 64'd0;
  end
  assign busy    = (r_state != IDLE);
  assign done    = (r_state == DONE);
  assign product = r_acc;
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_mcand <= '0;
      r_mplr  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && start) begin
        r_acc   <= '0;
        r_mcand <= op_a;
        r_mplr  <= op_b;
      end
      if (r_state == ADD) r_acc <= alu_F;
      if (r_state == SHL) r_mcand <= alu_F;
      if (r_state == SHR) r_mplr <= alu_F;
    end
  end
endmodule

// File: tb/tb_alu_mult_sequencer.sv
// tb_alu_mult_sequencer: directed multiplies checked every cycle against a schedule
// model built from the operand bits, plus literal latency/product/op-count checks.
module tb_alu_mult_sequencer;
  localparam logic [4:0] FS_ADD = 5'b01000, FS_SHL = 5'b10000, FS_SHR = 5'b10100;
  logic clock = 1'b0, reset = 1'b1, start = 1'b0;
  logic [63:0] op_a = '0, op_b = '0, alu_F, alu_A, alu_B, product;
  logic [4:0] alu_FS;
  logic busy, done;
  int tests = 0, fails = 0, n_add = 0, n_ops = 0, n_done = 0;
  logic [63:0] seq_word = '0;

  alu_mult_sequencer #(.FS_ADD(FS_ADD), .FS_SHL(FS_SHL), .FS_SHR(FS_SHR)) dut (
    .clock(clock), .reset(reset), .start(start), .op_a(op_a), .op_b(op_b), .alu_F(alu_F),
    .alu_FS(alu_FS), .alu_A(alu_A), .alu_B(alu_B), .product(product), .busy(busy), .done(done));

  always #5 clock = ~clock;

  always_comb begin
    case (alu_FS[4:2])
      3'b000:  alu_F = alu_A & alu_B;
      3'b001:  alu_F = alu_A | alu_B;
      3'b010:  alu_F = alu_A + alu_B;
      3'b011:  alu_F = alu_A - alu_B;
      3'b100:  alu_F = alu_A << alu_B[5:0];
      3'b101:  alu_F = alu_A >> alu_B[5:0];
      default: alu_F = alu_A ^ alu_B;
    endcase
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Model: one entry per busy cycle, derived from long-hand multiplication
  typedef struct packed {logic [4:0] fs; logic [63:0] a; logic [63:0] b; logic [63:0] p; logic d;} ent_t;
  ent_t q[$];
  logic [63:0] m_prod = '0;
  bit armed = 0;

  function automatic void build(input logic [63:0] a, input logic [63:0] b);
    logic [63:0] acc = '0;
    while (b != 0) begin
      if (b[0]) begin
        q.push_back('{fs: FS_ADD, a: acc, b: a, p: acc, d: 1'b0});
        acc = acc + a;
      end
      q.push_back('{fs: FS_SHL, a: a, b: 64'd1, p: acc, d: 1'b0});
      a = a * 2;
      q.push_back('{fs: FS_SHR, a: b, b: 64'd1, p: acc, d: 1'b0});
      b = b / 2;
    end
    q.push_back('{fs: 5'd0, a: 64'd0, b: 64'd0, p: acc, d: 1'b1});
    m_prod = acc;
  endfunction

  always @(posedge clock) begin
    armed = 1;
    if (reset) begin
      q.delete();
      m_prod = '0;
    end else if (q.size() != 0) void'(q.pop_front());
    else if (start) build(op_a, op_b);
  end

  always @(negedge clock) begin
    ent_t e;
    if (armed) begin
      e = (q.size() != 0) ? q[0] : '{fs: 5'd0, a: 64'd0, b: 64'd0, p: m_prod, d: 1'b0};
      chk("busy", {63'd0, busy}, {63'd0, q.size() != 0});
      chk("done", {63'd0, done}, {63'd0, e.d});
      chk("alu_FS", {59'd0, alu_FS}, {59'd0, e.fs});
      chk("alu_A", alu_A, e.a);
      chk("alu_B", alu_B, e.b);
      chk("product", product, e.p);
      if (alu_FS == FS_ADD) n_add++;
      if (alu_FS != 0) begin
        n_ops++;
        seq_word = {seq_word[58:0], alu_FS};
      end
      if (done) n_done++;
    end
  end

  task automatic run(input string name, input logic [63:0] a, input logic [63:0] b, input logic [63:0] exp_p,
                     input int exp_lat, input int exp_adds, input int exp_ops, input bit meddle);
    int cyc;
    n_add = 0; n_ops = 0; n_done = 0; seq_word = '0;
    op_a = a; op_b = b; start = 1;
    @(negedge clock); #1;
    start = 0; cyc = 1;
    while (!done && cyc < 400) begin
      if (meddle) begin
        op_a = 64'd100; op_b = 64'd3;
        start = (cyc == 2);
      end
      @(negedge clock); #1;
      cyc++;
    end
    if (!done) $display("FAIL %s_timeout: got no done want done by cycle %0d", name, exp_lat);
    chk({name, "_latency"}, 64'(cyc), 64'(exp_lat));
    chk({name, "_product"}, product, exp_p);
    chk({name, "_adds"}, 64'(n_add), 64'(exp_adds));
    chk({name, "_ops"}, 64'(n_ops), 64'(exp_ops));
    if (meddle) begin
      start = 1;
      @(negedge clock); #1;
      chk({name, "_start_in_done_ignored"}, {63'd0, busy}, 64'd0);
      start = 0;
    end
    @(negedge clock); #1;
  endtask

  initial begin
    repeat (2) @(negedge clock);
    #1;
    chk("reset_product", product, 64'd0);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_done", {63'd0, done}, 64'd0);
    chk("reset_fs", {59'd0, alu_FS}, 64'd0);
    chk("reset_ab", alu_A | alu_B, 64'd0);
    reset = 0;
    @(negedge clock); #1;
    run("m3x5", 64'd3, 64'd5, 64'd15, 9, 2, 8, 0);
    chk("m3x5_seq", seq_word, {24'd0, FS_ADD, FS_SHL, FS_SHR, FS_SHL, FS_SHR, FS_ADD, FS_SHL, FS_SHR});
    run("zero", 64'hDEADBEEF, 64'd0, 64'd0, 1, 0, 0, 0);
    run("allones", '1, '1, 64'd1, 193, 64, 192, 0);
    run("msb", 64'd7, 64'h8000000000000000, 64'h8000000000000000, 130, 1, 129, 0);
    n_done = 0;
    op_a = 64'd3; op_b = 64'd5; start = 1;
    @(negedge clock); #1;
    start = 0;
    repeat (3) @(negedge clock);
    #1;
    reset = 1;
    @(negedge clock); #1;
    reset = 0;
    chk("abort_product", product, 64'd0);
    chk("abort_busy", {63'd0, busy}, 64'd0);
    repeat (12) @(negedge clock);
    #1;
    chk("abort_no_done", 64'(n_done), 64'd0);
    run("m6x7", 64'd6, 64'd7, 64'd42, 10, 3, 9, 0);
    run("busy_start", 64'd3, 64'd5, 64'd15, 9, 2, 8, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
